mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide port clk_in, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_in, input, 1: reset, synchronous, active-low.
REQ-003 SHALL provide port rdy_in, input, 1: global enable; when low, all registers hold.
REQ-004 SHALL provide port mem_din, input, 8: RAM read byte, valid one cycle after mem_a is sampled.
REQ-005 SHALL provide port mem_dout, output, 8: RAM write byte.
REQ-006 SHALL provide port mem_a, output, 32: RAM byte address.
REQ-007 SHALL provide port mem_wr, output, 1: 1 = write mem_dout to mem_a this cycle.
REQ-008 SHALL provide port io_buffer_full, input, 1: I/O write buffer full.
REQ-009 SHALL provide port clear, input, 1: pipeline flush; aborts instruction fetch.
REQ-010 SHALL provide port if_ask, input, 1: instruction-fetch request, held until if_valid.
REQ-011 SHALL provide port if_addr, input, 32: fetch address, stable while if_ask is high.
REQ-012 SHALL provide port if_valid, output, 1: one-cycle fetch-complete pulse.
REQ-013 SHALL provide port if_inst, output, 32: fetched word, little-endian.
REQ-014 SHALL provide port ls_ask, input, 1: load/store request, held until ls_valid.
REQ-015 SHALL provide port ls_wr, input, 1: 1 = store, 0 = load.
REQ-016 SHALL provide port ls_size, input, 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-017 SHALL provide port ls_addr, input, 32: load/store address.
REQ-018 SHALL provide port ls_data, input, 32: store data; low n bytes are used.
REQ-019 SHALL provide port ls_valid, output, 1: one-cycle load/store-complete pulse.
REQ-020 SHALL provide port ls_rdata, output, 32: load data, zero-extended.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, LOAD, STORE, DONE.
REQ-022 SHALL accept requests only in IDLE with clear low for fetch; ls_ask SHALL win over if_ask when both are high.
REQ-023 SHALL apply accept edge E0 (IDLE->FETCH/LOAD): latch addr/size, set mem_a<=addr, mem_wr<=0, byte counter 0.
REQ-024 SHALL, in a read of n bytes (fetch n=4), drive mem_a<=addr+k at edge Ek for k<n, and capture byte k from mem_din at edge E(k+2) into bits [8k+7:8k].
REQ-025 SHALL, at edge E(n+1), go to DONE and set if_valid or ls_valid to 1 with complete data; word fetch valid is at E5, byte load valid is at E2.
REQ-026 SHALL, for a store (IDLE->STORE at E0), drive mem_a<=addr+k, mem_dout<=ls_data[8k+7:8k], mem_wr<=1 at edge Ek for k<n; at edge En it SHALL set mem_wr<=0, set ls_valid<=1, and go to DONE.
REQ-027 SHALL, for a store with addr[17:16]==2'b11 while io_buffer_full is high, issue no byte (mem_wr<=0, counter held) until io_buffer_full is low.
REQ-028 SHALL hold the valid pulse for exactly one cycle in DONE, with no acceptance; DONE->IDLE at the next edge, and valid returns to 0.
REQ-029 SHALL, when clear is high at an edge while in FETCH, go to IDLE with mem_wr=0 and no if_valid; a fetch in DONE still completes its pulse.
REQ-030 SHALL not let clear affect LOAD or STORE.
REQ-031 SHALL compute addr+k modulo 2^32, with no alignment requirement.
REQ-032 SHALL, when rdy_in is low, hold all state and outputs except mem_wr, which SHALL be forced to 0 combinationally.
REQ-033 SHALL keep mem_wr at 0 in every state except STORE byte-issue cycles.

Reset
REQ-034 SHALL, when rst_in is low at an edge, set state IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_valid=0, if_inst=0, ls_valid=0, ls_rdata=0, counter=0, including mid-operation; a partially written store is not completed.

Verification
REQ-035 SHALL cover word fetch from 0x0000_1000 with RAM bytes 13,05,00,00 -> if_valid only at E5, if_inst=0x0000_0513.
REQ-036 SHALL cover if_ask and ls_ask (load byte 0x2000 = 0xF0) raised the same cycle -> ls_valid at E2 with ls_rdata=0x0000_00F0, then fetch accepted after DONE.
REQ-037 SHALL cover a store half 0xBEEF to 0x0000_0101 -> mem_wr=1 with (0x101,EF) then (0x102,BE), ls_valid at E2, no wr after.
REQ-038 SHALL cover a store byte to 0x0003_0000 with io_buffer_full high for 3 cycles -> no mem_wr during those 3 cycles, then a single write and ls_valid.
REQ-039 SHALL cover clear pulsed at E2 of a fetch -> state IDLE, no if_valid, mem_wr=0; a new fetch is accepted the next cycle.
REQ-040 SHALL cover rst_in low mid-store, and rdy_in low for 2 cycles mid-load -> reset values on rst_in low; on rdy_in low, mem_wr=0, valid slips by exactly 2 cycles, and data is correct.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller and its environment: the RAM
// byte port, the instruction-fetch port and the load/store port.
//
// Handshake: a requester raises *_ask with stable address/data and holds it
// until it sees the matching one-cycle *_valid pulse. The controller accepts
// only while idle, so *_ask has no separate ready; *_valid is the only
// completion signal and is never asserted without a prior accepted request.
//
// "slave" is the controller's view; "master" is the view of everything
// around it (cores and RAM).
interface mem_ctrl_if;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        clear;
   logic        if_ask;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_inst;
   logic        ls_ask;
   logic        ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_data;
   logic        ls_valid;
   logic [31:0] ls_rdata;

   modport slave (
      input  mem_din, io_buffer_full, clear,
      input  if_ask, if_addr,
      input  ls_ask, ls_wr, ls_size, ls_addr, ls_data,
      output mem_dout, mem_a, mem_wr,
      output if_valid, if_inst,
      output ls_valid, ls_rdata
   );

   modport master (
      output mem_din, io_buffer_full, clear,
      output if_ask, if_addr,
      output ls_ask, ls_wr, ls_size, ls_addr, ls_data,
      input  mem_dout, mem_a, mem_wr,
      input  if_valid, if_inst,
      input  ls_valid, ls_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Arbitrates between instruction fetch and
// load/store, then walks the RAM byte port one address per cycle. Reads
// assemble little-endian words from a RAM with one cycle of read latency;
// stores issue one byte per cycle and can be throttled by a full I/O buffer.
module mem_ctrl (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   mem_ctrl_if.slave  bus,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] base_addr;
   logic [31:0] st_data;
   logic [31:0] rd_buf;
   logic [2:0]  n_bytes;
   logic [2:0]  cnt;
   logic [31:0] mem_a_r;
   logic [7:0]  mem_dout_r;
   logic        wr_r;
   logic        if_valid_r;
   logic [31:0] if_inst_r;
   logic        ls_valid_r;
   logic [31:0] ls_rdata_r;

   // Reads: cnt holds the number of edges seen since the accept edge, so the
   // edge being processed is cnt+1 and the byte arriving on mem_din now is
   // the one whose address went out two edges earlier (index cnt-1).
   logic [2:0]  edge_idx;
   logic [2:0]  cnt_m1;
   logic [1:0]  byte_sel;
   logic [31:0] rd_next;
   logic        io_block_now;
   logic        io_block;

   assign edge_idx = cnt + 3'd1;
   assign cnt_m1   = cnt - 3'd1;
   assign byte_sel = cnt_m1[1:0];

   // The I/O region is addr[17:16] == 2'b11; stores there stall on a full buffer.
   assign io_block_now = (bus.ls_addr[17:16] == 2'b11) && bus.io_buffer_full;
   assign io_block     = (base_addr[17:16] == 2'b11) && bus.io_buffer_full;

   function automatic logic [2:0] size_to_n(input logic [1:0] size);
      case (size)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Merge the byte arriving this cycle into the read buffer (none on the first edge).
   always_comb begin
      rd_next = rd_buf;
      if (cnt != 3'd0) rd_next[{byte_sel, 3'b000} +: 8] = bus.mem_din;
   end

   // Controller FSM with registered outputs; rdy_in low freezes everything.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         base_addr  <= 32'd0;
         st_data    <= 32'd0;
         rd_buf     <= 32'd0;
         n_bytes    <= 3'd0;
         cnt        <= 3'd0;
         mem_a_r    <= 32'd0;
         mem_dout_r <= 8'd0;
         wr_r       <= 1'b0;
         if_valid_r <= 1'b0;
         if_inst_r  <= 32'd0;
         ls_valid_r <= 1'b0;
         ls_rdata_r <= 32'd0;
      end else if (rdy_in) begin
         case (state)
            IDLE: begin
               wr_r <= 1'b0;
               if (bus.ls_ask) begin
                  base_addr <= bus.ls_addr;
                  st_data   <= bus.ls_data;
                  n_bytes   <= size_to_n(bus.ls_size);
                  rd_buf    <= 32'd0;
                  mem_a_r   <= bus.ls_addr;
                  if (!bus.ls_wr) begin
                     state <= LOAD;
                     cnt   <= 3'd0;
                  end else if (io_block_now) begin
                     state <= STORE;
                     cnt   <= 3'd0;
                  end else begin
                     // Byte 0 of a store goes out on the accept edge itself.
                     state      <= STORE;
                     mem_dout_r <= bus.ls_data[7:0];
                     wr_r       <= 1'b1;
                     cnt        <= 3'd1;
                  end
               end else if (bus.if_ask && !bus.clear) begin
                  state     <= FETCH;
                  base_addr <= bus.if_addr;
                  n_bytes   <= 3'd4;
                  rd_buf    <= 32'd0;
                  mem_a_r   <= bus.if_addr;
                  cnt       <= 3'd0;
               end
            end

            FETCH, LOAD: begin
               wr_r <= 1'b0;
               if (state == FETCH && bus.clear) begin
                  // Flush abandons the fetch silently.
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  if (edge_idx < n_bytes) mem_a_r <= base_addr + {29'd0, edge_idx};
                  rd_buf <= rd_next;
                  cnt    <= edge_idx;
                  if (edge_idx == n_bytes + 3'd1) begin
                     state <= DONE;
                     if (state == FETCH) begin
                        if_valid_r <= 1'b1;
                        if_inst_r  <= rd_next;
                     end else begin
                        ls_valid_r <= 1'b1;
                        ls_rdata_r <= rd_next;
                     end
                  end
               end
            end

            STORE: begin
               if (cnt == n_bytes) begin
                  wr_r       <= 1'b0;
                  ls_valid_r <= 1'b1;
                  state      <= DONE;
               end else if (io_block) begin
                  wr_r <= 1'b0;
               end else begin
                  mem_a_r    <= base_addr + {29'd0, cnt};
                  mem_dout_r <= st_data[{cnt[1:0], 3'b000} +: 8];
                  wr_r       <= 1'b1;
                  cnt        <= cnt + 3'd1;
               end
            end

            DONE: begin
               wr_r       <= 1'b0;
               if_valid_r <= 1'b0;
               ls_valid_r <= 1'b0;
               cnt        <= 3'd0;
               state      <= IDLE;
            end

            default: begin
               wr_r  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Write strobe is cut immediately when the system is stalled.
   assign bus.mem_wr   = wr_r & rdy_in;
   assign bus.mem_a    = mem_a_r;
   assign bus.mem_dout = mem_dout_r;
   assign bus.if_valid = if_valid_r;
   assign bus.if_inst  = if_inst_r;
   assign bus.ls_valid = ls_valid_r;
   assign bus.ls_rdata = ls_rdata_r;
   assign dbg_state    = state;

endmodule
